// File: rtl/axi4l_mem_slave.sv
// axi4l_mem_slave: AXI4-Lite slave over a single-port word array with byte strobes,
// one-entry AW/W holding buffers and SLVERR decode. Define AXI4L_MEM_ALIGN_CHECK_EN to reject unaligned accesses.
module axi4l_mem_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    logic ok;
    ok = ((addr >> (LSB + IDX_W)) == '0);
`ifdef AXI4L_MEM_ALIGN_CHECK_EN
    ok = ok && (addr[LSB-1:0] == '0);
`endif
    return ok;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[LSB +: IDX_W];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  en;
  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] aw_addr_p0;
  logic [DATA_WIDTH-1:0] w_data_p0;
  logic [STRB_W-1:0]     w_strb_p0;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  wr_ok;
  logic                  ar_hs;
  logic                  rd_busy;
  logic                  smp_vld;
  logic [ADDR_WIDTH-1:0] smp_addr;
  logic                  rd_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) en <= 1'b0;
    else          en <= 1'b1;
  end

  // Write path: independent AW and W buffers, joined at commit
  assign awready = en && !aw_full;
  assign wready  = en && !w_full;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign commit  = aw_full && w_full && (!bvalid || bready);
  assign wr_ok   = addr_ok(aw_addr_p0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (aw_hs)       aw_full <= 1'b1;
      else if (commit) aw_full <= 1'b0;
      if (w_hs)        w_full <= 1'b1;
      else if (commit) w_full <= 1'b0;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_p0 <= awaddr;
    if (w_hs) begin
      w_data_p0 <= wdata;
      w_strb_p0 <= wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && wr_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_p0[i]) mem[addr_idx(aw_addr_p0)][8*i +: 8] <= w_data_p0[8*i +: 8];
      end
    end
  end

  // Read path: single outstanding read, optional address register before the array sample
  assign arready = en && !rd_busy && (!rvalid || rready);
  assign ar_hs   = arvalid && arready;

  if (READ_LATENCY == 2) begin : g_rl2
    logic                  vld_p0;
    logic [ADDR_WIDTH-1:0] ar_addr_p0;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vld_p0 <= 1'b0;
      else          vld_p0 <= ar_hs;
    end

    always_ff @(posedge clk) begin
      if (ar_hs) ar_addr_p0 <= araddr;
    end

    assign rd_busy  = vld_p0;
    assign smp_vld  = vld_p0;
    assign smp_addr = ar_addr_p0;
  end else begin : g_rl1
    assign rd_busy  = 1'b0;
    assign smp_vld  = ar_hs;
    assign smp_addr = araddr;
  end

  assign rd_ok = addr_ok(smp_addr);

  // Sample stage: array read lands in the R holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (smp_vld) begin
      rvalid <= 1'b1;
      rdata  <= rd_ok ? mem[addr_idx(smp_addr)] : '0;
      rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4l_mem_slave.sv
// Randomized self-checking bench for axi4l_mem_slave against a word-array reference model.
module tb_axi4l_mem_slave;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int RL    = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;

  always #5 clk = ~clk;

  axi4l_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ok(input logic [31:0] a);
    bit ok;
    ok = (a >> 2) < DEPTH;
`ifdef AXI4L_MEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return exp_ok(a) ? ref_mem[a[9:2]] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    if (exp_ok(a)) ref_mem[a[9:2]] = (ref_mem[a[9:2]] & ~m) | (d & m);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    int cyc = 0;
    int lat = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    logic [1:0] exp_resp;
    exp_resp = exp_ok(a) ? 2'b00 : 2'b10;
    bready = 1'b0; awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 100) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1; cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_hs_bound", cyc < 100, 1);
    while (!bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("wr_latency", lat, 1);
    model_write(a, d, s);
    for (int i = 0; i < b_dly; i++) begin
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_resp", bresp, exp_resp);
      @(posedge clk); #1;
    end
    chk("bresp", bresp, exp_resp);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("b_single", bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly);
    int cyc = 0;
    int lat = 1;
    bit done = 0, hs;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    exp_d = exp_rdata(a);
    exp_r = exp_ok(a) ? 2'b00 : 2'b10;
    rready = 1'b0; araddr = a;
    while (!done && cyc < 100) begin
      arvalid = 1'b1;
      hs = arready;
      @(posedge clk); #1; cyc++;
      if (hs) done = 1;
    end
    arvalid = 1'b0;
    chk("rd_hs_bound", cyc < 100, 1);
    while (!rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("rd_latency", lat, RL);
    for (int i = 0; i < r_dly; i++) begin
      chk("r_hold_valid", rvalid, 1);
      chk("r_hold_data", rdata, exp_d);
      chk("r_hold_arready", arready, 0);
      @(posedge clk); #1;
    end
    chk("rdata", rdata, exp_d);
    chk("rresp", rresp, exp_r);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("r_single", rvalid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int w;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    reset_n = 1'b1;
    chk("en_before_edge", awready, 0);
    @(posedge clk); #1;
    chk("en_awready", awready, 1);
    chk("en_wready", wready, 1);
    chk("en_arready", arready, 1);

    // reset in the middle of a write: AW accepted and held, W pending
    awaddr = 32'h40; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    @(posedge clk); #1;
    chk("aw_captured", awready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_awready", awready, 0);
    chk("rst_mid_wready", wready, 0);
    chk("rst_mid_arready", arready, 0);
    @(posedge clk); #1;
    awvalid = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);
    do_write(32'h44, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(32'h40, 0);
    do_read(32'h44, 0);

    // strobes
    do_write(32'h10, 32'hAABBCCDD, 4'b1111, 0, 0, 0);
    do_write(32'h10, 32'h11223344, 4'b0101, 0, 0, 0);
    chk("strobe_model", ref_mem[4], 32'hAA22CC44);
    do_read(32'h10, 4);

    // W ahead of AW, B back-pressured
    do_write(32'h20, 32'hDEADBEEF, 4'hF, 3, 0, 5);
    do_read(32'h20, 0);

    // out of range, no aliasing into word 0
    do_write(32'h400, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_read(32'h400, 0);
    do_read(32'h0, 0);

    // read sampled on the same edge a write commits to the same word
    awaddr = 32'h30; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h30; arvalid = (RL == 2);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = (RL == 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("col_bvalid", bvalid, 1);
    chk("col_rvalid", rvalid, 1);
    chk("col_rdata", rdata, 32'h0);
    chk("col_rresp", rresp, 0);
    model_write(32'h30, 32'h5, 4'hF);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    do_read(32'h30, 0);
    do_read(32'h31, 0);

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(250, 262)) : int'($urandom_range(0, 15));
      a = 32'(w * 4);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        do_read(a, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
